am_pattern_sequencer: RTL and testbench

AM_PATTERN_SEQUENCER -- requirements
Module: am_pattern_sequencer

---
 rtl/am_pattern_sequencer.sv | 119 +++++++++++
 tb/tb_am_pattern_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/am_pattern_sequencer.sv
// rtl/am_pattern_sequencer.sv - beat-driven AM pattern sequencer with shadow/active pattern registers
// Walks NUM_SEG segments of 2**SEG_LEN_LOG2 beats and flags the AM level of the current segment.
module am_pattern_sequencer #(
  parameter int                 NUM_SEG      = 16,
  parameter int                 SEG_LEN_LOG2 = 2,
  parameter int                 BEAT_W       = 12,
  parameter logic [NUM_SEG-1:0] DEFAULT_PAT  = 16'h19AD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       hold,
  input  logic                       beat_tick,
  input  logic                       loop_en,
  input  logic                       pat_wr,
  input  logic [NUM_SEG-1:0]         pat_wdata,
  output logic                       is_AM,
  output logic [BEAT_W-1:0]          beat_num,
  output logic [$clog2(NUM_SEG)-1:0] seg_idx,
  output logic                       busy,
  output logic                       wrap_pulse,
  output logic                       done
);

  localparam int                SEG_W     = $clog2(NUM_SEG);
  localparam int                TOTAL     = NUM_SEG << SEG_LEN_LOG2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t             state, state_n;
  logic [NUM_SEG-1:0] shadow, shadow_n;
  logic [NUM_SEG-1:0] active, active_n;
  logic [BEAT_W-1:0]  beat_n, beat_inc;
  logic               is_am_n, busy_n, wrap_n, done_n;
  logic [NUM_SEG-1:0] pat_src;

  assign seg_idx = beat_num[SEG_LEN_LOG2 +: SEG_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shadow     <= DEFAULT_PAT;
      active     <= DEFAULT_PAT;
      beat_num   <= '0;
      is_AM      <= 1'b0;
      busy       <= 1'b0;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      active     <= active_n;
      beat_num   <= beat_n;
      is_AM      <= is_am_n;
      busy       <= busy_n;
      wrap_pulse <= wrap_n;
      done       <= done_n;
    end
  end

  always_comb begin
    // A write landing on the same edge as a start/wrap must reach the active pattern directly.
    pat_src  = pat_wr ? pat_wdata : shadow;
    beat_inc = beat_num + BEAT_W'(1);
    state_n  = state;
    shadow_n = pat_src;
    active_n = active;
    beat_n   = beat_num;
    is_am_n  = is_AM;
    wrap_n   = 1'b0;
    done_n   = 1'b0;

    if (stop) begin
      state_n = S_IDLE;
      beat_n  = '0;
      is_am_n = 1'b0;
    end else if (start && (state == S_IDLE || state == S_DONE)) begin
      state_n  = S_RUN;
      beat_n   = '0;
      active_n = pat_src;
      is_am_n  = pat_src[0];
    end else begin
      case (state)
        S_RUN: begin
          if (hold) begin
            state_n = S_PAUSE;
          end else if (beat_tick) begin
            if (beat_num == LAST_BEAT) begin
              if (loop_en) begin
                beat_n   = '0;
                active_n = pat_src;
                is_am_n  = pat_src[0];
                wrap_n   = 1'b1;
              end else begin
                state_n = S_DONE;
                is_am_n = 1'b0;
                done_n  = 1'b1;
              end
            end else begin
              beat_n  = beat_inc;
              is_am_n = active[beat_inc[SEG_LEN_LOG2 +: SEG_W]];
            end
          end
        end
        S_PAUSE: begin
          if (!hold) state_n = S_RUN;
        end
        default: begin
          is_am_n = 1'b0;
        end
      endcase
    end

    busy_n = (state_n == S_RUN) || (state_n == S_PAUSE);
  end

endmodule

// File: tb/tb_am_pattern_sequencer.sv
// tb/tb_am_pattern_sequencer.sv - self-checking bench for am_pattern_sequencer
// Vector table for control priorities, scoreboard-driven sequences for the long corner cases.
module tb_am_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, hold, beat_tick, loop_en, pat_wr;
  logic [15:0] pat_wdata;
  logic        is_am;
  logic [11:0] beat_num;
  logic [3:0]  seg_idx;
  logic        busy, wrap_pulse, done;

  logic        start2, beat_tick2, pat_wr2;
  logic [7:0]  pat_wdata2;
  logic        is_am2;
  logic [5:0]  beat_num2;
  logic [2:0]  seg_idx2;
  logic        busy2, wrap_pulse2, done2;

  always #5 clk = ~clk;

  am_pattern_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .beat_tick(beat_tick), .loop_en(loop_en), .pat_wr(pat_wr), .pat_wdata(pat_wdata),
    .is_AM(is_am), .beat_num(beat_num), .seg_idx(seg_idx), .busy(busy),
    .wrap_pulse(wrap_pulse), .done(done)
  );

  am_pattern_sequencer #(.NUM_SEG(8), .SEG_LEN_LOG2(3), .BEAT_W(6), .DEFAULT_PAT(8'h3C)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop), .hold(hold),
    .beat_tick(beat_tick2), .loop_en(loop_en), .pat_wr(pat_wr2), .pat_wdata(pat_wdata2),
    .is_AM(is_am2), .beat_num(beat_num2), .seg_idx(seg_idx2), .busy(busy2),
    .wrap_pulse(wrap_pulse2), .done(done2)
  );

  typedef struct {
    string tag;
    int    beat;
    logic  am;
    logic  busy;
    logic  done;
    logic  wrap;
    logic  u2;
  } exp_t;

  typedef struct {
    logic start, stop, hold, tick;
    int   beat;
    logic am, busy;
  } vec_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] pat_m;
  logic [7:0]  pat2_m;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string tag, int beat, logic am, logic bz, logic dn, logic wr, logic u2);
    exp_t e;
    e.tag = tag; e.beat = beat; e.am = am; e.busy = bz; e.done = dn; e.wrap = wr; e.u2 = u2;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    if (!e.u2) begin
      chk({e.tag, " beat"}, int'(beat_num), e.beat);
      chk({e.tag, " seg"},  int'(seg_idx), e.beat >> 2);
      chk({e.tag, " am"},   int'(is_am), int'(e.am));
      chk({e.tag, " busy"}, int'(busy), int'(e.busy));
      chk({e.tag, " done"}, int'(done), int'(e.done));
      chk({e.tag, " wrap"}, int'(wrap_pulse), int'(e.wrap));
    end else begin
      chk({e.tag, " beat"}, int'(beat_num2), e.beat);
      chk({e.tag, " seg"},  int'(seg_idx2), e.beat >> 3);
      chk({e.tag, " am"},   int'(is_am2), int'(e.am));
      chk({e.tag, " busy"}, int'(busy2), int'(e.busy));
      chk({e.tag, " done"}, int'(done2), int'(e.done));
    end
  endtask

  task automatic tick1(string tag, int beat, logic am, logic bz, logic dn, logic wr);
    push(tag, beat, am, bz, dn, wr, 1'b0);
    beat_tick = 1'b1;
    cyc();
    beat_tick = 1'b0;
    pop_check();
  endtask

  task automatic start1(string tag, logic am);
    push(tag, 0, am, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    pop_check();
  endtask

  task automatic stop1(string tag);
    push(tag, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    pop_check();
  endtask

  initial begin
    vec_t vt[11];
    rst_n = 1'b0; start = 0; stop = 0; hold = 0; beat_tick = 0; loop_en = 0;
    pat_wr = 0; pat_wdata = '0;
    start2 = 0; beat_tick2 = 0; pat_wr2 = 0; pat_wdata2 = '0;
    pat_m = 16'h19AD;

    cyc(); cyc();
    chk("reset beat", int'(beat_num), 0);
    chk("reset am",   int'(is_am), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset wrap", int'(wrap_pulse), 0);
    rst_n = 1'b1;
    cyc();

    // start stop hold tick | beat am busy
    vt[0]  = '{1, 1, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 1, 0, 0, 0};
    vt[2]  = '{1, 0, 0, 1, 0, 1, 1};
    vt[3]  = '{0, 0, 0, 1, 1, 1, 1};
    vt[4]  = '{1, 0, 0, 1, 2, 1, 1};
    vt[5]  = '{0, 0, 1, 1, 2, 1, 1};
    vt[6]  = '{0, 0, 1, 1, 2, 1, 1};
    vt[7]  = '{0, 0, 0, 1, 2, 1, 1};
    vt[8]  = '{0, 0, 0, 1, 3, 1, 1};
    vt[9]  = '{0, 0, 0, 1, 4, 0, 1};
    vt[10] = '{0, 1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      start = vt[i].start; stop = vt[i].stop; hold = vt[i].hold; beat_tick = vt[i].tick;
      push($sformatf("vec%0d", i), vt[i].beat, vt[i].am, vt[i].busy, 1'b0, 1'b0, 1'b0);
      cyc();
      start = 0; stop = 0; hold = 0; beat_tick = 0;
      pop_check();
    end

    // Full single pass with the default pattern.
    start1("A start", pat_m[0]);
    for (int k = 1; k < 64; k++) tick1($sformatf("A t%0d", k), k, pat_m[k >> 2], 1'b1, 1'b0, 1'b0);
    tick1("A last", 63, 1'b0, 1'b0, 1'b1, 1'b0);
    push("A after", 63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat_tick = 1'b1;
    cyc();
    beat_tick = 1'b0;
    pop_check();

    // Looping with a shadow write mid-pass: pass 1 unaffected, pass 2 all ones.
    loop_en = 1'b1;
    start1("B start", pat_m[0]);
    for (int k = 1; k < 64; k++) begin
      if (k == 10) begin pat_wr = 1'b1; pat_wdata = 16'hFFFF; end
      tick1($sformatf("B p1 t%0d", k), k, pat_m[k >> 2], 1'b1, 1'b0, 1'b0);
      pat_wr = 1'b0;
    end
    tick1("B wrap", 0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 64; k++) tick1($sformatf("B p2 t%0d", k), k, 1'b1, 1'b1, 1'b0, 1'b0);
    stop1("B stop");
    loop_en = 1'b0;

    // Write-through on start, hold at beat 5, then stop at beat 30.
    pat_m = 16'hF0F0;
    pat_wr = 1'b1; pat_wdata = pat_m;
    start1("C start", pat_m[0]);
    pat_wr = 1'b0;
    for (int k = 1; k <= 5; k++) tick1($sformatf("C t%0d", k), k, pat_m[k >> 2], 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) tick1($sformatf("C hold%0d", k), 5, pat_m[1], 1'b1, 1'b0, 1'b0);
    hold = 1'b0;
    push("C unhold", 5, pat_m[1], 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    pop_check();
    for (int k = 6; k <= 30; k++) tick1($sformatf("C t%0d", k), k, pat_m[k >> 2], 1'b1, 1'b0, 1'b0);
    stop1("C stop");

    // Asynchronous reset mid-sequence restores the default pattern.
    start1("E start", pat_m[0]);
    for (int k = 1; k <= 20; k++) tick1($sformatf("E t%0d", k), k, pat_m[k >> 2], 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("E rst beat", int'(beat_num), 0);
    chk("E rst am",   int'(is_am), 0);
    chk("E rst busy", int'(busy), 0);
    cyc();
    rst_n = 1'b1;
    tick1("E idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    pat_m = 16'h19AD;
    start1("E restart", pat_m[0]);
    for (int k = 1; k <= 12; k++) tick1($sformatf("E r%0d", k), k, pat_m[k >> 2], 1'b1, 1'b0, 1'b0);
    stop1("E stop");

    // Second geometry: 8 segments of 8 beats.
    pat2_m = 8'hA5;
    pat_wr2 = 1'b1; pat_wdata2 = pat2_m;
    push("F wr", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    pat_wr2 = 1'b0;
    pop_check();
    push("F start", 0, pat2_m[0], 1'b1, 1'b0, 1'b0, 1'b1);
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    pop_check();
    for (int k = 1; k <= 64; k++) begin
      if (k < 64) push($sformatf("F t%0d", k), k, pat2_m[k >> 3], 1'b1, 1'b0, 1'b0, 1'b1);
      else        push("F last", 63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      beat_tick2 = 1'b1;
      cyc();
      beat_tick2 = 1'b0;
      pop_check();
    end

    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
